stall_data_memory: RTL and testbench
====================================

# stall_data_memory

Parametrised data memory with a valid/ready request handshake and programmable wait states, replacing the single-cycle data memory so that a multi-cycle or pipelined RISC-V core can stall on memory. Supports byte, halfword and word loads and stores, signed or unsigned load extension, and reports misaligned or out-of-range accesses. It sits between the core's load/store path and the memory array and serves one request at a time.

## Interface
Parameters:
- `DATA_W`, 32: data width in bits. Fixed at 32; byte-lane logic assumes 4 lanes.
- `ADDR_W`, 32: byte-address width.
- `DEPTH`, 256: number of 32-bit words in the array.
- `RD_LAT`, 2: wait cycles inserted for a read, 0..15.
- `WR_LAT`, 1: wait cycles inserted for a write, 0..15.

Ports:
- `clk`, input, 1: clock. The block uses a single clock and all state changes on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: block can accept a request.
- `req_we`, input, 1: 1 selects a store, 0 selects a load.
- `req_addr`, input, ADDR_W: byte address.
- `req_wdata`, input, DATA_W: store data, right-aligned.
- `req_size`, input, 2: 00 selects byte, 01 halfword, 10 word. The value 11 is treated as an error.
- `req_unsigned`, input, 1: for loads, 1 zero-extends and 0 sign-extends.
- `resp_valid`, output, 1: one-cycle completion pulse.
- `resp_rdata`, output, DATA_W: extended load data. It is 0 for stores and for errors.
- `resp_err`, output, 1: the access was misaligned, out of range, or had `req_size`=11. Valid only while `resp_valid` is 1.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - `req_ready` is 1.
  - When `req_valid` is 1, latch `req_we`, `req_addr`, `req_wdata`, `req_size` and `req_unsigned`.
  - Load the counter with the latency for that request type (`RD_LAT` or `WR_LAT`).
  - Next state is WAIT if the latency is greater than 0; otherwise RESP.
- **WAIT**
  - Decrement the counter each cycle.
  - On the cycle the counter equals 1, the next state is RESP.
  - The array access happens on that same edge: read data is captured and the store is committed.
  - With latency 0, the access happens on the accept edge instead.
- **RESP**
  - `resp_valid` is 1 for exactly one cycle, then the FSM returns to IDLE.
  - `req_ready` is 0, so no back-to-back acceptance is possible.
- Inputs are ignored whenever `req_ready` is 0. Only the latched copies are used.

Addressing and lanes (little-endian):
- Word index is `req_addr[ADDR_W-1:2]`.
- A byte access uses lane `addr[1:0]`.
- A halfword access uses lanes {`addr[1]`*2+1, `addr[1]`*2}.
- A store writes only the selected lanes. The other bytes of the word are preserved.
- For a load, the selected lane(s) are shifted down to bit 0, then zero- or sign-extended to 32 bits.

Errors:
- An access is an error if any of these hold:
  - it is a halfword with `addr[0]`=1;
  - it is a word with `addr[1:0]`≠0;
  - the word index is ≥ `DEPTH`;
  - `req_size` is 11.
- On error, nothing is written, `resp_rdata` is 0, and `resp_err` is 1 in the RESP cycle. Latency is unchanged.

Reset:
- While `rst` is 1 at a clock edge:
  - state returns to IDLE and the counter goes to 0;
  - every array word is cleared to 0;
  - `resp_valid`, `resp_err` and `busy` go to 0, `resp_rdata` goes to 0, and `req_ready` goes to 1 once reset is released.
- Reset during WAIT aborts the access: no store is committed and no response is issued.
- Reset has priority over everything else.

## Timing
- Request accepted at edge T with latency L:
  - `resp_valid` is high during cycle T+L+1;
  - `req_ready` is high again in cycle T+L+2.
- Throughput is one request per L+2 cycles.
- Store data is visible to a load accepted at any edge after the store's RESP cycle.
- `busy` equals NOT `req_ready` (outside reset).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset clear:** assert `rst` for 2 cycles, then load word from 0x00 → `resp_rdata`=0x00000000 and `resp_err`=0.
- **Word round-trip, RD_LAT=2, WR_LAT=1:** store word 0xDEADBEEF to 0x10, accepted at T. Expect `resp_valid` at T+2 and `req_ready` at T+3. Then load word from 0x10, accepted at T'. Expect `resp_rdata`=0xDEADBEEF with `resp_valid` exactly at T'+3.
- **Sub-word stores and loads:**
  - Store byte 0x80 to 0x13 over existing 0xDEADBEEF, giving 0x80ADBEEF.
  - Load signed byte from 0x13 → 0xFFFFFF80.
  - Load unsigned byte from 0x13 → 0x00000080.
  - Load unsigned half from 0x12 → 0x000080AD.
- **Errors:**
  - Load half from 0x11 → `resp_err`=1, `resp_rdata`=0.
  - Store word to 0x402 (misaligned), then to 0x400 (index 256 with DEPTH=256) → `resp_err`=1, and a subsequent load of word 0x000 shows it unchanged.
- **Handshake hold:** keep `req_valid`=1 with changing `req_addr` during WAIT → only the originally latched request completes. Exactly one `resp_valid` is issued per acceptance.
- **Reset mid-WAIT:** store 0x12345678 to 0x20, then assert `rst` in the first WAIT cycle → no `resp_valid`. A following load of 0x20 returns 0x00000000.

Source files
------------

// File: rtl/stall_data_memory.sv
// Data memory with a valid/ready request port and programmable read/write
// wait states. It serves one request at a time and supports byte, halfword
// and word accesses with little-endian lanes and signed/unsigned load extension.
module stall_data_memory #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned WR_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam int unsigned IDX_W  = ADDR_W - 2;
   localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned LANES  = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                req_ready_q, req_ready_d;
   logic                busy_q, busy_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   // Access operands: live inputs on a zero-latency accept, latched copies otherwise
   logic                acc_we;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;
   logic [1:0]          acc_size;
   logic                acc_uns;
   logic [IDX_W-1:0]    acc_idx;
   logic [MEM_AW-1:0]   mem_idx;
   logic                acc_err;
   logic [LANES-1:0]    acc_be;
   logic [DATA_W-1:0]   acc_wlane;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   rd_shift;
   logic [DATA_W-1:0]   rd_ext;
   logic                access;
   logic                mem_we;
   logic [CNT_W-1:0]    lat;

   // Decode the access: error check, write lanes and extended load data
   always_comb begin
      acc_we    = (state_q == S_IDLE) ? req_we       : we_q;
      acc_addr  = (state_q == S_IDLE) ? req_addr     : addr_q;
      acc_wdata = (state_q == S_IDLE) ? req_wdata    : wdata_q;
      acc_size  = (state_q == S_IDLE) ? req_size     : size_q;
      acc_uns   = (state_q == S_IDLE) ? req_unsigned : uns_q;
      acc_idx   = acc_addr[ADDR_W-1:2];
      mem_idx   = acc_idx[MEM_AW-1:0];
      acc_err   = 1'b0;
      acc_be    = '0;
      acc_wlane = acc_wdata;
      rd_word   = mem_q[mem_idx];
      rd_shift  = rd_word;
      rd_ext    = rd_word;

      case (acc_size)
         2'b00: begin
            acc_be    = LANES'(1) << acc_addr[1:0];
            acc_wlane = {LANES{acc_wdata[7:0]}};
            rd_shift  = rd_word >> {acc_addr[1:0], 3'b000};
            rd_ext    = acc_uns ? {{(DATA_W-8){1'b0}}, rd_shift[7:0]}
                                : {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
         end
         2'b01: begin
            acc_err   = acc_addr[0];
            acc_be    = acc_addr[1] ? LANES'(4'b1100) : LANES'(4'b0011);
            acc_wlane = {2{acc_wdata[15:0]}};
            rd_shift  = rd_word >> {acc_addr[1], 4'b0000};
            rd_ext    = acc_uns ? {{(DATA_W-16){1'b0}}, rd_shift[15:0]}
                                : {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
         end
         2'b10: begin
            acc_err   = |acc_addr[1:0];
            acc_be    = '1;
         end
         default: begin
            acc_err   = 1'b1;
         end
      endcase

      if (acc_idx >= IDX_W'(DEPTH)) begin
         acc_err = 1'b1;
      end
      if (acc_we || acc_err) begin
         rd_ext = '0;
      end
   end

   // Next-state, wait counter, request latch and registered output values
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      size_d       = size_q;
      uns_d        = uns_q;
      access       = 1'b0;
      lat          = req_we ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               size_d  = req_size;
               uns_d   = req_unsigned;
               cnt_d   = lat;
               if (lat != '0) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_RESP;
                  access  = 1'b1;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_RESP;
               access  = 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      mem_we       = access && acc_we && !acc_err;
      resp_valid_d = (state_d == S_RESP);
      resp_err_d   = access && acc_err;
      resp_rdata_d = access ? rd_ext : '0;
      req_ready_d  = (state_d == S_IDLE);
      busy_d       = (state_d != S_IDLE);
   end

   // State, latched request and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         req_ready_q  <= req_ready_d;
         busy_q       <= busy_d;
      end
   end

   // Memory array: cleared by reset, byte-lane writes on the access edge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         for (int b = 0; b < int'(LANES); b++) begin
            if (acc_be[b]) begin
               mem_q[mem_idx][8*b +: 8] <= acc_wlane[8*b +: 8];
            end
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_stall_data_memory.sv
// Bench for stall_data_memory: directed vector table, hand-written handshake
// and reset sequences, then random traffic against a byte-array model.
module tb_stall_data_memory;

   localparam int unsigned DEPTH  = 256;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned WR_LAT = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem_b [DEPTH*4];

   always #5 clk = ~clk;

   stall_data_memory #(
      .DATA_W (32),
      .ADDR_W (32),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT),
      .WR_LAT (WR_LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .busy         (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   function automatic void model_clear();
      for (int i = 0; i < int'(DEPTH*4); i++) mem_b[i] = 8'h00;
   endfunction

   // Reference: byte-addressed memory, little-endian assembly and extension
   function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic uns,
                                 output logic [31:0] exp_rd, output logic exp_err);
      int n;
      logic [31:0] v;
      exp_err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
      exp_rd = 32'h0;
      if (!exp_err) begin
         n = 1 << size;
         if (we) begin
            for (int i = 0; i < n; i++) mem_b[int'(addr) + i] = wdata[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(mem_b[int'(addr) + i]) << (8*i));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            exp_rd = v;
         end
      end
   endfunction

   // One request: present it, wait for accept, time the response, check the handshake
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input bit spam,
                         output logic [31:0] rd, output logic er);
      int n;
      int k;
      int lat;
      lat = we ? int'(WR_LAT) : int'(RD_LAT);
      req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
      req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) timeout("accept_wait");
      @(posedge clk); #1;
      k = 0;
      if (!spam) req_valid = 1'b0;
      while (resp_valid !== 1'b1 && k < 50) begin
         chk("busy_not_ready", 32'(busy), 32'(!req_ready));
         if (spam) begin
            req_addr  = 32'h40 + 32'($urandom_range(0, 15) << 2);
            req_wdata = $urandom;
            req_we    = 1'($urandom_range(0, 1));
            req_size  = 2'b10;
         end
         @(posedge clk); #1; k++;
      end
      if (k >= 50) timeout("resp_wait");
      chk("resp_latency", 32'(k), 32'(lat));
      chk("ready_low_in_resp", 32'(req_ready), 32'd0);
      rd = resp_rdata;
      er = resp_err;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("resp_single_pulse", 32'(resp_valid), 32'd0);
      chk("ready_after_resp", 32'(req_ready), 32'd1);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs [17];

   initial begin
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          pulses;

      vecs[0]  = '{1'b0, 32'h000, 32'h0,        2'b10, 1'b0, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b1, 32'h010, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b0, 32'h010, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF,  1'b0};
      vecs[3]  = '{1'b1, 32'h013, 32'h0000_0080, 2'b00, 1'b0, 32'h0000_0000, 1'b0};
      vecs[4]  = '{1'b0, 32'h010, 32'h0,        2'b10, 1'b0, 32'h80ADBEEF,  1'b0};
      vecs[5]  = '{1'b0, 32'h013, 32'h0,        2'b00, 1'b0, 32'hFFFF_FF80, 1'b0};
      vecs[6]  = '{1'b0, 32'h013, 32'h0,        2'b00, 1'b1, 32'h0000_0080, 1'b0};
      vecs[7]  = '{1'b0, 32'h012, 32'h0,        2'b01, 1'b1, 32'h0000_80AD, 1'b0};
      vecs[8]  = '{1'b0, 32'h011, 32'h0,        2'b01, 1'b0, 32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b1, 32'h402, 32'hAAAA5555, 2'b10, 1'b0, 32'h0000_0000, 1'b1};
      vecs[10] = '{1'b1, 32'h400, 32'hAAAA5555, 2'b10, 1'b0, 32'h0000_0000, 1'b1};
      vecs[11] = '{1'b0, 32'h000, 32'h0,        2'b10, 1'b0, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b0, 32'h010, 32'h0,        2'b11, 1'b0, 32'h0000_0000, 1'b1};
      vecs[13] = '{1'b0, 32'h012, 32'h0,        2'b01, 1'b0, 32'hFFFF_80AD, 1'b0};
      vecs[14] = '{1'b1, 32'h016, 32'h1234CAFE, 2'b01, 1'b0, 32'h0000_0000, 1'b0};
      vecs[15] = '{1'b0, 32'h014, 32'h0,        2'b10, 1'b0, 32'hCAFE_0000, 1'b0};
      vecs[16] = '{1'b0, 32'h010, 32'h0,        2'b00, 1'b0, 32'hFFFF_FFEF, 1'b0};

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = 2'b00; req_unsigned = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_resp_err", 32'(resp_err), 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);

      // Directed vectors
      for (int i = 0; i < 17; i++) begin
         do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, 1'b0, rd, er);
         model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, mrd, mer);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      end

      // Reset in the first WAIT cycle of a store aborts it
      req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'b10;
      req_unsigned = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         if (resp_valid === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      chk("rst_abort_no_resp", 32'(pulses), 32'd0);
      chk("rst_abort_ready", 32'(req_ready), 32'd1);
      chk("rst_abort_busy", 32'(busy), 32'd0);
      model_clear();
      do_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, rd, er);
      chk("rst_abort_load_0x20", rd, 32'h0000_0000);
      do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, rd, er);
      chk("rst_clears_0x10", rd, 32'h0000_0000);

      // Inputs changing during WAIT must not disturb the latched request
      do_req(1'b1, 32'h30, 32'h11112222, 2'b10, 1'b0, 1'b1, rd, er);
      model(1'b1, 32'h30, 32'h11112222, 2'b10, 1'b0, mrd, mer);
      chk("hold_store_err", 32'(er), 32'd0);
      do_req(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 1'b1, rd, er);
      chk("hold_load_0x30", rd, 32'h11112222);
      for (int w = 0; w < 16; w++) begin
         do_req(1'b0, 32'h40 + 32'(w*4), 32'h0, 2'b10, 1'b0, 1'b0, rd, er);
         model(1'b0, 32'h40 + 32'(w*4), 32'h0, 2'b10, 1'b0, mrd, mer);
         chk($sformatf("hold_untouched_%0h", 32'h40 + 32'(w*4)), rd, mrd);
      end

      // Random traffic against the model
      for (int t = 0; t < 300; t++) begin
         logic        we, uns;
         logic [1:0]  size;
         logic [31:0] addr, wdata;
         int          sel, widx;
         sel  = int'($urandom_range(0, 9));
         size = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
         widx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH-4, DEPTH+3))
                                            : int'($urandom_range(0, 31));
         addr = 32'(widx) << 2;
         if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(0, 3));
         else if (size == 2'b00) addr = addr | 32'($urandom_range(0, 3));
         else if (size == 2'b01) addr = addr | (32'($urandom_range(0, 1)) << 1);
         we    = 1'($urandom_range(0, 1));
         uns   = 1'($urandom_range(0, 1));
         wdata = $urandom;
         do_req(we, addr, wdata, size, uns, 1'b0, rd, er);
         model(we, addr, wdata, size, uns, mrd, mer);
         chk($sformatf("rand%0d_rdata_a%0h_s%0d", t, addr, size), rd, mrd);
         chk($sformatf("rand%0d_err_a%0h_s%0d", t, addr, size), 32'(er), 32'(mer));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
